// File: rtl/main_memory_pkg.sv
// Shared constants for main_memory: FSM state encoding, request-queue depth, latency counter width.
package main_memory_pkg;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LAT_MIN     = 2;
    localparam int unsigned LAT_MAX     = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/main_memory_req_fifo.sv
// Two-entry request queue of packed {rw, addr, data}; slot0 is always the head entry.
module main_memory_req_fifo
    import main_memory_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full_c,
    output logic             empty_c
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (count == 2'd0);
    assign full_c  = (count == 2'(QUEUE_DEPTH));
    assign do_pop  = pop && !empty_c;
    // A pop on the same edge frees a slot, so a push into a full queue is still taken.
    assign do_push = push && (!full_c || do_pop);
    assign head    = slot0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty_c) slot0 <= wdata;
                    else         slot1 <= wdata;
                end
                2'b01: slot0 <= slot1;
                2'b11: begin
                    if (full_c) begin
                        slot0 <= slot1;
                        slot1 <= wdata;
                    end else begin
                        slot0 <= wdata;
                    end
                end
                default: ;
            endcase
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/main_memory.sv
// Word-addressed backing RAM with fixed-latency responses, a 2-entry request queue and a shared
// tristate data bus driven only during a read's completion cycle.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int unsigned d_width = 8,
    parameter int unsigned a_width = 8,
    parameter int unsigned latency = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr,
    inout  wire  [d_width-1:0] data,
    input  logic               rw,
    input  logic               ce,
    output logic               rdy,
    output logic               busy,
    output logic               err
);

    localparam int unsigned ENTRY_W = 1 + a_width + d_width;
    localparam int unsigned DEPTH   = 1 << a_width;
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(latency - 2);

    if (latency < LAT_MIN || latency > LAT_MAX) begin : g_bad_latency
        $error("main_memory: latency %0d outside legal range 2..15", latency);
    end

    logic [d_width-1:0] mem [DEPTH];

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               drv_en;
    logic [d_width-1:0] rd_q;

    logic [ENTRY_W-1:0] q_wdata;
    logic [ENTRY_W-1:0] q_head;
    logic [1:0]         q_count;
    logic               q_full_c;
    logic               q_empty_c;
    logic               pop_c;
    logic               drop_c;

    logic               head_rw;
    logic [a_width-1:0] head_addr;
    logic [d_width-1:0] head_data;

    // Write data is only captured for writes; reads carry zero payload.
    assign q_wdata = {rw, addr, (rw ? {d_width{1'b0}} : data)};
    assign pop_c   = (state == ST_DONE);
    assign drop_c  = ce && q_full_c && !pop_c;

    assign head_rw   = q_head[ENTRY_W-1];
    assign head_addr = q_head[d_width +: a_width];
    assign head_data = q_head[d_width-1:0];

    main_memory_req_fifo #(
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (ce),
        .pop     (pop_c),
        .wdata   (q_wdata),
        .head    (q_head),
        .count   (q_count),
        .full_c  (q_full_c),
        .empty_c (q_empty_c)
    );

    // Sequencer: IDLE -> WAIT (latency-2 .. 0) -> DONE; DONE chains straight into WAIT when work remains.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rdy    <= 1'b0;
            drv_en <= 1'b0;
            rd_q   <= '0;
            err    <= 1'b0;
        end else begin
            rdy    <= 1'b0;
            drv_en <= 1'b0;
            if (drop_c) err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!q_empty_c) begin
                        state <= ST_WAIT;
                        cnt   <= LAT_RELOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state  <= ST_DONE;
                        rdy    <= 1'b1;
                        drv_en <= head_rw;
                        rd_q   <= mem[head_addr];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Head leaves on this edge; anything behind it starts its own latency window.
                    if (q_count > 2'd1) begin
                        state <= ST_WAIT;
                        cnt   <= LAT_RELOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Writes commit as their DONE cycle ends, so a later queued read sees the new value.
    always_ff @(posedge clk) begin
        if (state == ST_DONE && !head_rw) begin
            mem[head_addr] <= head_data;
        end
    end

    assign data = drv_en ? rd_q : {d_width{1'bz}};
    assign busy = (state != ST_IDLE) || (q_count != 2'd0);

endmodule

// File: tb/tb_main_memory.sv
// Scoreboarded bench for main_memory: latency-4 instance under directed and random traffic,
// plus a latency-2 instance for the short-latency corner.
`timescale 1ns/1ps
module tb_main_memory;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 8;
    localparam int          LAT  = 4;
    localparam int          LAT2 = 2;
    localparam logic [DW-1:0] BUS_IDLE = 8'hFF;

    typedef struct {
        int          a;
        int          c;
        bit          rw;
        logic [7:0]  data;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr;
    logic [AW-1:0] addr, addr2;
    logic          rw, ce, rw2, ce2;
    wire  [DW-1:0] data, data2;
    logic          rdy, busy, err, rdy2, busy2, err2;
    logic          tb_drv, tb_drv2;
    logic [DW-1:0] tb_wdata, tb_wdata2;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    bit [7:0] ref_mem [256];
    bit       written [256];
    int   last_c = -100;
    int   drop_edge = -1;

    assign data  = tb_drv  ? tb_wdata  : 'z;
    assign data2 = tb_drv2 ? tb_wdata2 : 'z;

    for (genvar i = 0; i < DW; i++) begin : g_pu
        pullup (data[i]);
        pullup (data2[i]);
    end

    main_memory #(.d_width(DW), .a_width(AW), .latency(LAT)) u_dut (
        .clk (clk), .clr (clr), .addr (addr), .data (data),
        .rw (rw), .ce (ce), .rdy (rdy), .busy (busy), .err (err)
    );

    main_memory #(.d_width(DW), .a_width(AW), .latency(LAT2)) u_dut2 (
        .clk (clk), .clr (clr), .addr (addr2), .data (data2),
        .rw (rw2), .ce (ce2), .rdy (rdy2), .busy (busy2), .err (err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit read_done_near(input int t);
        foreach (sb[i]) if (sb[i].rw && (sb[i].c == t || sb[i].c == t + 1)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1; the request is sampled at the next edge.
    task automatic issue(input bit r, input logic [7:0] a, input logic [7:0] d);
        int   t;
        int   occ;
        exp_t e;
        while (!r && read_done_near(cyc)) idle(1);
        t   = cyc + 1;
        occ = 0;
        foreach (sb[i]) if (sb[i].a < t && sb[i].c >= t) occ++;
        ce = 1'b1; rw = r; addr = a;
        tb_drv = !r; tb_wdata = d;
        if (occ < 2) begin
            e.a    = t;
            e.c    = ((t > last_c) ? t : last_c) + LAT;
            e.rw   = r;
            e.data = r ? ref_mem[a] : d;
            if (!r) begin
                ref_mem[a] = d;
                written[a] = 1'b1;
            end
            last_c = e.c;
            sb.push_back(e);
        end else if (drop_edge < 0) begin
            drop_edge = t;
        end
        @(posedge clk); #1;
        ce = 1'b0; rw = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    task automatic run2(input bit r, input logic [7:0] a, input logic [7:0] d);
        ce2 = 1'b1; rw2 = r; addr2 = a; tb_drv2 = !r; tb_wdata2 = d;
        @(posedge clk); #1;
        ce2 = 1'b0; rw2 = 1'b1; tb_drv2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat2_rdy", 32'(rdy2), 32'(k == 2));
            check("lat2_busy", 32'(busy2), 32'(k <= 2));
            check("lat2_bus", 32'(data2), (r && k == 2) ? 32'(d) : 32'(BUS_IDLE));
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compares every cycle's rdy/busy/err/bus against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            bit bexp;
            bexp = 1'b0;
            foreach (sb[i]) if (sb[i].a <= cyc && sb[i].c >= cyc) bexp = 1'b1;
            check("busy", 32'(busy), 32'(bexp));
            check("err", 32'(err), 32'(drop_edge >= 0 && cyc >= drop_edge));
            if (rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_rdy", 32'(rdy), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdy_cycle", 32'(cyc), 32'(mon_e.c));
                    if (mon_e.rw) check("read_data", 32'(data), 32'(mon_e.data));
                    else if (!tb_drv) check("bus_released", 32'(data), 32'(BUS_IDLE));
                end
            end else begin
                if (sb.size() != 0 && sb[0].c <= cyc) begin
                    check("missing_rdy", 32'(rdy), 32'd1);
                    void'(sb.pop_front());
                end
                if (!tb_drv) check("bus_released", 32'(data), 32'(BUS_IDLE));
            end
        end
    end

    initial begin
        int c1;
        int sel;
        logic [7:0] a;
        bit rd;
        clr = 1'b1; ce = 1'b0; rw = 1'b1; addr = '0; tb_drv = 1'b0; tb_wdata = '0;
        ce2 = 1'b0; rw2 = 1'b1; addr2 = '0; tb_drv2 = 1'b0; tb_wdata2 = '0;
        #1 clr = 1'b0;
        #2;
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_bus", 32'(data), 32'(BUS_IDLE));
        check("reset_bus2", 32'(data2), 32'(BUS_IDLE));
        #4 clr = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single write then read of the same word.
        issue(1'b0, 8'h10, 8'hA5);
        drain();
        issue(1'b1, 8'h10, 8'h00);
        drain();

        // Write immediately followed by a read of the same address.
        issue(1'b0, 8'h20, 8'h3C);
        issue(1'b1, 8'h20, 8'h00);
        drain();

        // Three back-to-back requests overflow the queue; err must stick.
        issue(1'b0, 8'h30, 8'h11);
        issue(1'b0, 8'h31, 8'h22);
        issue(1'b0, 8'h32, 8'h33);
        drain();
        idle(3);

        // Reset in the middle of a read's wait: everything clears, no late rdy.
        issue(1'b1, 8'h10, 8'h00);
        idle(2);
        #2 clr = 1'b0;
        mon_en = 1'b0;
        #1;
        check("midreset_rdy", 32'(rdy), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        check("midreset_bus", 32'(data), 32'(BUS_IDLE));
        sb.delete();
        drop_edge = -1;
        last_c = -100;
        #3 clr = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        idle(8);

        // New read presented during the DONE cycle while one request is still queued.
        issue(1'b1, 8'h10, 8'h00);
        issue(1'b1, 8'h20, 8'h00);
        c1 = sb[0].c;
        while (cyc < c1) idle(1);
        issue(1'b1, 8'h30, 8'h00);
        drain();

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                idle($urandom_range(1, 6));
            end else begin
                a  = 8'($urandom_range(0, 255));
                rd = ($urandom_range(0, 1) == 1) && written[a];
                issue(rd, a, 8'($urandom_range(0, 254)));
            end
        end
        drain();

        // Shortest legal latency.
        run2(1'b0, 8'h05, 8'h77);
        run2(1'b1, 8'h05, 8'h77);
        check("lat2_err", 32'(err2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
